alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 8: number of queue entries (power of two, 4..16).
REQ-002 SHALL have parameter N_BYPASS, default 3: number of bypass buses snooped for wakeup.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-004 flush  in  1  discard all queued instructions.
REQ-005 dispatch_valid  in  1  dispatch offers one ALU instruction.
REQ-006 dispatch_ready  out  1  queue can accept one instruction this cycle.
REQ-007 dispatch_inst  in  dispatch_to_iq_bus_t  inst, phy_dest, rob_entry_num, src1/src2 tag, ready and value.
REQ-008 bypass_bus  in  bypass_bus_t[N_BYPASS]  {we[3:0], phy_dest, result} per producer.
REQ-009 issue_to_alu_valid  out  1  an instruction is issued to the ALU this cycle.
REQ-010 issue_inst  out  issue_to_execute_bus_t  issued inst, phy_dest, src1_value, src2_value, rob_entry_num.

Function
REQ-011 Entry state SHALL be: valid, inst, phy_dest, rob_entry_num, and per source tag, rdy, value.
REQ-012 dispatch_ready SHALL be 1 iff at least one entry is invalid at the start of the cycle; same-cycle issue frees nothing for dispatch.
REQ-013 Dispatch on dispatch_valid && dispatch_ready SHALL write the lowest-index free entry at the clock edge.
REQ-014 Wakeup: a source with rdy=0 and a bus with |we=1 and phy_dest==tag SHALL latch result and set rdy=1 at the edge; lowest bus index wins on multiple matches.
REQ-015 Sources of the instruction being dispatched SHALL be matched against the same-cycle bypass buses (no lost wakeup).
REQ-016 An entry is ready when valid and both rdy=1; readiness SHALL be evaluated on registered state only (bypass-to-issue latency 1 cycle).
REQ-017 Select SHALL issue at most one ready entry per cycle, combinationally; issue_to_alu_valid=1 iff some entry is ready and flush=0.
REQ-018 The issued entry SHALL be invalidated at the same edge; there is no downstream backpressure.
REQ-019 issue_inst SHALL be '0 when issue_to_alu_valid=0.
REQ-020 flush=1 SHALL invalidate all entries at the edge and ignore same-cycle dispatch; issue_to_alu_valid=0 during flush.
REQ-021 The queue SHALL never overflow, and no entry SHALL be issued twice.

Reset
REQ-022 On reset all entries invalid, all age state cleared; dispatch_ready=1 and issue_to_alu_valid=0 in the cycle following reset.
REQ-023 Reset asserted mid-operation SHALL discard all entries identically to flush.

Configuration
REQ-024 With IQ_AGE_ORDER_EN defined, select SHALL pick the oldest ready entry using an IQ_DEPTH x IQ_DEPTH age matrix; a dispatched entry is younger than all valid entries.
REQ-025 Without IQ_AGE_ORDER_EN, select SHALL pick the lowest-index ready entry, and no age matrix SHALL be built.

Structure
REQ-026 dispatch_to_iq_bus_t, bypass_bus_t, issue_to_execute_bus_t, reg_addr_t and IQ_DEPTH default SHALL reside in the shared cpu package/header.
REQ-027 Selection logic SHALL be one sub-module, iq_select (ready vector in, one-hot grant out; age matrix when IQ_AGE_ORDER_EN is defined).

Verification
REQ-028 Dispatch inst with src1_rdy=src2_rdy=1 (values 5, 7) into an empty queue -> issue_to_alu_valid=1 the next cycle with src1_value=5, src2_value=7.
REQ-029 Dispatch with src1 tag 12 not ready; bypass {4'hF, 12, 32'hDEAD_BEEF} in cycle N -> issue in cycle N+1 with src1_value=32'hDEAD_BEEF.
REQ-030 Bypass for tag 12 present in the same cycle as dispatch of a src1 tag 12 -> captured; issued the next cycle.
REQ-031 Fill 8 entries, all blocked -> dispatch_ready=0; release one -> it issues and dispatch_ready=1 the following cycle.
REQ-032 With IQ_AGE_ORDER_EN: dispatch A into entry 3, free entries 0..2, dispatch B into entry 0, wake both together -> A issues first, then B.
REQ-033 flush with 5 valid entries and a concurrent dispatch -> issue_to_alu_valid=0 that cycle, queue empty and dispatch_ready=1 the next cycle.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// Shared CPU types for the ALU issue queue: dispatch, bypass and issue buses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Build option: IQ_AGE_ORDER_EN selects oldest-first issue in the queue.
package alu_issue_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int XLEN             = 32;
  localparam int PREG_W           = 6;   // physical register tag width
  localparam int ROB_W            = 6;   // reorder buffer index width

  typedef logic [PREG_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   data_t;
  typedef logic [31:0]       inst_t;
  typedef logic [ROB_W-1:0]  rob_idx_t;

  // One ALU instruction as offered by dispatch. Also the per-entry payload.
  typedef struct packed {
    inst_t     inst;
    reg_addr_t phy_dest;
    rob_idx_t  rob_entry_num;
    reg_addr_t src1_tag;
    logic      src1_rdy;
    data_t     src1_value;
    reg_addr_t src2_tag;
    logic      src2_rdy;
    data_t     src2_value;
  } dispatch_to_iq_bus_t;

  // Result broadcast from one producer; any nonzero byte enable marks it live.
  typedef struct packed {
    logic [3:0] we;
    reg_addr_t  phy_dest;
    data_t      result;
  } bypass_bus_t;

  typedef struct packed {
    inst_t     inst;
    reg_addr_t phy_dest;
    data_t     src1_value;
    data_t     src2_value;
    rob_idx_t  rob_entry_num;
  } issue_to_execute_bus_t;

endpackage

// File: rtl/iq_select.sv
// Issue select: turns the ready vector into a one-hot grant.
// Latency: combinational grant; age state (if built) updates at the clock edge.
// Backpressure: none; a grant is always consumed by the caller.
// Ports: ready (entry ready vector), grant (one-hot). With IQ_AGE_ORDER_EN:
//   clk, reset, clear (flush), alloc (one-hot entry written this cycle).
module iq_select
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
`ifdef IQ_AGE_ORDER_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DEPTH-1:0] alloc,
`endif
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);

`ifdef IQ_AGE_ORDER_EN
  // older[i][j] = 1 means entry i was written before entry j.
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blocked;

  // A newly written entry is younger than everything: its row is cleared and
  // its column set. Stale bits of invalid entries never matter because an
  // invalid entry is never ready.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older[k][j] <= 1'b0;
            if (j != k) older[j][k] <= 1'b1;
          end
        end
      end
    end
  end

  // An entry is granted when no other ready entry is older than it.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    grant = ready & ~blocked;
  end
`else
  // Lowest-index ready entry: isolate the least significant set bit.
  always_comb begin
    grant = ready & (~ready + DEPTH'(1));
  end
`endif

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: holds dispatched instructions until both sources are ready,
// snooping bypass buses for wakeup, and issues one ready entry per cycle.
// Latency: dispatch/wakeup to issue 1 cycle. Backpressure: dispatch_ready=0
// when all entries are valid at the start of the cycle; no issue backpressure.
// Ports: clk, reset (sync, active high), flush, dispatch_valid/ready/inst,
//   bypass_bus[N_BYPASS], issue_to_alu_valid, issue_inst.
// Build option: IQ_AGE_ORDER_EN issues the oldest ready entry instead of the
//   lowest-index one.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT,
  parameter int N_BYPASS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  input  dispatch_to_iq_bus_t   dispatch_inst,
  input  bypass_bus_t           bypass_bus [N_BYPASS],
  output logic                  issue_to_alu_valid,
  output issue_to_execute_bus_t issue_inst
);

  logic [IQ_DEPTH-1:0] valid_q;
  logic [IQ_DEPTH-1:0] free_vec;
  logic [IQ_DEPTH-1:0] alloc_vec;
  logic [IQ_DEPTH-1:0] ready_vec;
  logic [IQ_DEPTH-1:0] grant_vec;
  logic [IQ_DEPTH-1:0] issued_vec;
  logic                do_dispatch;

  dispatch_to_iq_bus_t ent_q [IQ_DEPTH];
  // Index IQ_DEPTH is the instruction being dispatched, so it sees the same
  // wakeups as the resident entries.
  dispatch_to_iq_bus_t cand  [IQ_DEPTH+1];
  dispatch_to_iq_bus_t woke  [IQ_DEPTH+1];

  // Only start-of-cycle occupancy counts; an entry issuing this cycle is not
  // reusable until the next one.
  assign free_vec       = ~valid_q;
  assign dispatch_ready = |free_vec;
  assign do_dispatch    = dispatch_valid && dispatch_ready && !flush;
  assign alloc_vec      = do_dispatch ? (free_vec & (~free_vec + IQ_DEPTH'(1)))
                                      : '0;

  // Readiness uses registered state only.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ready_vec[i] = valid_q[i] && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
    end
  end

  iq_select #(.DEPTH(IQ_DEPTH)) u_select (
`ifdef IQ_AGE_ORDER_EN
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .alloc (alloc_vec),
`endif
    .ready (ready_vec),
    .grant (grant_vec)
  );

  assign issue_to_alu_valid = (|ready_vec) && !flush;
  assign issued_vec         = grant_vec & {IQ_DEPTH{issue_to_alu_valid}};

  always_comb begin
    issue_inst = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (issued_vec[i]) begin
        issue_inst.inst          = ent_q[i].inst;
        issue_inst.phy_dest      = ent_q[i].phy_dest;
        issue_inst.src1_value    = ent_q[i].src1_value;
        issue_inst.src2_value    = ent_q[i].src2_value;
        issue_inst.rob_entry_num = ent_q[i].rob_entry_num;
      end
    end
  end

  // Wakeup: buses are scanned from highest to lowest index so the lowest
  // matching bus is the last writer and wins.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) cand[i] = ent_q[i];
    cand[IQ_DEPTH] = dispatch_inst;
    for (int i = 0; i <= IQ_DEPTH; i++) begin
      woke[i] = cand[i];
      for (int b = N_BYPASS - 1; b >= 0; b--) begin
        if (|bypass_bus[b].we) begin
          if (!cand[i].src1_rdy && bypass_bus[b].phy_dest == cand[i].src1_tag) begin
            woke[i].src1_rdy   = 1'b1;
            woke[i].src1_value = bypass_bus[b].result;
          end
          if (!cand[i].src2_rdy && bypass_bus[b].phy_dest == cand[i].src2_tag) begin
            woke[i].src2_rdy   = 1'b1;
            woke[i].src2_value = bypass_bus[b].result;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= (valid_q & ~issued_vec) | alloc_vec;
    end
  end

  // Payload needs no reset; it is qualified by valid_q everywhere.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (alloc_vec[i]) ent_q[i] <= woke[IQ_DEPTH];
      else              ent_q[i] <= woke[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: reset, ready dispatch, bypass wakeup,
// same-cycle capture, full queue, select order, flush and mid-run reset.
// Build option: IQ_AGE_ORDER_EN changes the expected order in the age step.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int NB = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  dispatch_valid;
  logic                  dispatch_ready;
  dispatch_to_iq_bus_t   dispatch_inst;
  bypass_bus_t           bb [NB];
  logic                  issue_to_alu_valid;
  issue_to_execute_bus_t issue_inst;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.IQ_DEPTH(8), .N_BYPASS(NB)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .dispatch_ready     (dispatch_ready),
    .dispatch_inst      (dispatch_inst),
    .bypass_bus         (bb),
    .issue_to_alu_valid (issue_to_alu_valid),
    .issue_inst         (issue_inst)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input data_t obs, input data_t exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input rob_idx_t obs, input rob_idx_t exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_bus();
    for (int b = 0; b < NB; b++) bb[b] = '0;
  endtask

  task automatic set_bus(input int b, input logic [3:0] we, input reg_addr_t t, input data_t v);
    bb[b].we       = we;
    bb[b].phy_dest = t;
    bb[b].result   = v;
  endtask

  function automatic dispatch_to_iq_bus_t mk(
    input inst_t inst, input reg_addr_t dest, input rob_idx_t rob,
    input reg_addr_t t1, input logic r1, input data_t v1,
    input reg_addr_t t2, input logic r2, input data_t v2);
    dispatch_to_iq_bus_t d;
    d.inst = inst;   d.phy_dest = dest; d.rob_entry_num = rob;
    d.src1_tag = t1; d.src1_rdy = r1;   d.src1_value = v1;
    d.src2_tag = t2; d.src2_rdy = r2;   d.src2_value = v2;
    return d;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_inst = '0;
    clr_bus();
    tick(); tick();
    reset = 1'b0; settle();
    chk_b("rst_dready", dispatch_ready, 1'b1);
    chk_b("rst_ivalid", issue_to_alu_valid, 1'b0);
    chk_b("rst_inst_zero", |issue_inst, 1'b0);

    // Both sources ready at dispatch: issues next cycle, not the same one.
    dispatch_valid = 1'b1;
    dispatch_inst = mk(32'h0000_0011, 6'd20, 6'd1, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    settle();
    chk_b("t1_not_same_cycle", issue_to_alu_valid, 1'b0);
    tick(); dispatch_valid = 1'b0; settle();
    chk_b("t1_valid", issue_to_alu_valid, 1'b1);
    chk_d("t1_src1", issue_inst.src1_value, 32'd5);
    chk_d("t1_src2", issue_inst.src2_value, 32'd7);
    chk_d("t1_inst", issue_inst.inst, 32'h0000_0011);
    chk_r("t1_rob", issue_inst.rob_entry_num, 6'd1);
    chk_b("t1_dest", issue_inst.phy_dest === 6'd20, 1'b1);
    tick(); settle();
    chk_b("t1_issued_once", issue_to_alu_valid, 1'b0);
    chk_b("t1_inst_zero", |issue_inst, 1'b0);

    // Wakeup via bypass in cycle N, issue in N+1; we=0 and other tags ignored;
    // lowest bus wins on a double match.
    dispatch_valid = 1'b1;
    dispatch_inst = mk(32'h22, 6'd21, 6'd2, 6'd12, 1'b0, 32'd0, 6'd3, 1'b1, 32'd3);
    tick(); dispatch_valid = 1'b0;
    set_bus(1, 4'h0, 6'd12, 32'hBAD0_0001);
    set_bus(2, 4'hF, 6'd13, 32'hBAD0_0002);
    settle();
    chk_b("t2_blocked", issue_to_alu_valid, 1'b0);
    tick(); clr_bus();
    set_bus(0, 4'hF, 6'd12, 32'hDEAD_BEEF);
    set_bus(2, 4'h1, 6'd12, 32'hCAFE_0000);
    settle();
    chk_b("t2_we0_ignored", issue_to_alu_valid, 1'b0);
    tick(); clr_bus(); settle();
    chk_b("t2_valid", issue_to_alu_valid, 1'b1);
    chk_d("t2_src1", issue_inst.src1_value, 32'hDEAD_BEEF);
    chk_d("t2_src2", issue_inst.src2_value, 32'd3);
    chk_r("t2_rob", issue_inst.rob_entry_num, 6'd2);
    tick(); settle();
    chk_b("t2_empty", issue_to_alu_valid, 1'b0);

    // Bypass in the dispatch cycle itself is captured.
    dispatch_valid = 1'b1;
    dispatch_inst = mk(32'h33, 6'd22, 6'd3, 6'd12, 1'b0, 32'd0, 6'd4, 1'b1, 32'd9);
    set_bus(1, 4'h2, 6'd12, 32'h1234_5678);
    settle();
    chk_b("t3_not_same_cycle", issue_to_alu_valid, 1'b0);
    tick(); dispatch_valid = 1'b0; clr_bus(); settle();
    chk_b("t3_valid", issue_to_alu_valid, 1'b1);
    chk_d("t3_src1", issue_inst.src1_value, 32'h1234_5678);
    chk_d("t3_src2", issue_inst.src2_value, 32'd9);
    tick();

    // Fill all 8 entries blocked on tags 40..47; entry i gets rob i.
    for (int i = 0; i < 8; i++) begin
      dispatch_valid = 1'b1;
      dispatch_inst = mk(inst_t'(32'h100 + i), reg_addr_t'(i), rob_idx_t'(i),
                         reg_addr_t'(40 + i), 1'b0, 32'd0, 6'd60, 1'b1, data_t'(i));
      tick();
    end
    // Offer a ready instruction while full: must not be accepted.
    dispatch_inst = mk(32'hEE, 6'd30, 6'd30, 6'd1, 1'b1, 32'hE1, 6'd2, 1'b1, 32'hE2);
    settle();
    chk_b("t4_full_dready", dispatch_ready, 1'b0);
    chk_b("t4_full_ivalid", issue_to_alu_valid, 1'b0);
    tick(); dispatch_valid = 1'b0;
    set_bus(0, 4'hF, 6'd45, 32'h55);
    settle();
    chk_b("t4_wake_cycle", issue_to_alu_valid, 1'b0);
    tick(); clr_bus(); settle();
    chk_b("t4_rel_valid", issue_to_alu_valid, 1'b1);
    chk_r("t4_rel_rob", issue_inst.rob_entry_num, 6'd5);
    chk_d("t4_rel_src1", issue_inst.src1_value, 32'h55);
    chk_b("t4_issue_frees_nothing", dispatch_ready, 1'b0);
    tick(); settle();
    chk_b("t4_dready_after", dispatch_ready, 1'b1);
    chk_b("t4_no_overflow", issue_to_alu_valid, 1'b0);

    // Entries 2 and 6 wake together: entry 2 is both lower and older.
    set_bus(0, 4'hF, 6'd46, 32'h66);
    set_bus(1, 4'hF, 6'd42, 32'h22);
    tick(); clr_bus(); settle();
    chk_r("t5_first", issue_inst.rob_entry_num, 6'd2);
    chk_d("t5_first_src1", issue_inst.src1_value, 32'h22);
    tick(); settle();
    chk_r("t5_second", issue_inst.rob_entry_num, 6'd6);
    tick(); settle();
    chk_b("t5_idle", issue_to_alu_valid, 1'b0);

    // Entries 0,1,3,4,7 valid. Make entry 0 ready, then flush with a dispatch.
    set_bus(0, 4'hF, 6'd40, 32'h40);
    tick(); clr_bus(); settle();
    chk_b("t6_ready_before_flush", issue_to_alu_valid, 1'b1);
    flush = 1'b1; dispatch_valid = 1'b1;
    dispatch_inst = mk(32'h77, 6'd31, 6'd31, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2);
    settle();
    chk_b("t6_flush_ivalid", issue_to_alu_valid, 1'b0);
    chk_b("t6_flush_inst_zero", |issue_inst, 1'b0);
    tick(); flush = 1'b0; dispatch_valid = 1'b0; settle();
    chk_b("t6_dready", dispatch_ready, 1'b1);
    chk_b("t6_empty", issue_to_alu_valid, 1'b0);
    set_bus(0, 4'hF, 6'd41, 32'h41);
    set_bus(1, 4'hF, 6'd43, 32'h43);
    set_bus(2, 4'hF, 6'd47, 32'h47);
    tick(); clr_bus(); settle();
    chk_b("t6_nothing_left", issue_to_alu_valid, 1'b0);

    // Age step: A lands in entry 3, B later in entry 0, both woken together.
    for (int i = 0; i < 4; i++) begin
      dispatch_valid = 1'b1;
      dispatch_inst = mk(inst_t'(32'h200 + i), reg_addr_t'(10 + i), rob_idx_t'(10 + i),
                         reg_addr_t'(50 + i), 1'b0, 32'd0, 6'd60, 1'b1, 32'd0);
      tick();
    end
    dispatch_valid = 1'b0;
    set_bus(0, 4'hF, 6'd50, 32'd0);
    set_bus(1, 4'hF, 6'd51, 32'd0);
    set_bus(2, 4'hF, 6'd52, 32'd0);
    tick(); clr_bus(); settle();
    chk_r("t7_free_e0", issue_inst.rob_entry_num, 6'd10);
    tick(); settle();
    chk_r("t7_free_e1", issue_inst.rob_entry_num, 6'd11);
    tick(); settle();
    chk_r("t7_free_e2", issue_inst.rob_entry_num, 6'd12);
    tick();
    dispatch_valid = 1'b1;
    dispatch_inst = mk(32'h300, 6'd14, 6'd14, 6'd54, 1'b0, 32'd0, 6'd60, 1'b1, 32'd0);
    tick(); dispatch_valid = 1'b0;
    set_bus(0, 4'hF, 6'd54, 32'hB);
    set_bus(1, 4'hF, 6'd53, 32'hA);
    tick(); clr_bus(); settle();
`ifdef IQ_AGE_ORDER_EN
    chk_r("t7_first", issue_inst.rob_entry_num, 6'd13);
    chk_d("t7_first_src1", issue_inst.src1_value, 32'hA);
    tick(); settle();
    chk_r("t7_second", issue_inst.rob_entry_num, 6'd14);
`else
    chk_r("t7_first", issue_inst.rob_entry_num, 6'd14);
    chk_d("t7_first_src1", issue_inst.src1_value, 32'hB);
    tick(); settle();
    chk_r("t7_second", issue_inst.rob_entry_num, 6'd13);
`endif
    tick(); settle();
    chk_b("t7_idle", issue_to_alu_valid, 1'b0);

    // Reset mid-run with a concurrent dispatch discards everything.
    dispatch_valid = 1'b1;
    dispatch_inst = mk(32'h400, 6'd15, 6'd15, 6'd55, 1'b0, 32'd0, 6'd60, 1'b1, 32'd0);
    tick();
    dispatch_inst = mk(32'h401, 6'd16, 6'd16, 6'd56, 1'b0, 32'd0, 6'd60, 1'b1, 32'd0);
    tick();
    reset = 1'b1;
    dispatch_inst = mk(32'h402, 6'd17, 6'd17, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2);
    tick(); reset = 1'b0; dispatch_valid = 1'b0; settle();
    chk_b("t8_dready", dispatch_ready, 1'b1);
    chk_b("t8_ivalid", issue_to_alu_valid, 1'b0);
    set_bus(0, 4'hF, 6'd55, 32'd0);
    set_bus(1, 4'hF, 6'd56, 32'd0);
    tick(); clr_bus(); settle();
    chk_b("t8_empty", issue_to_alu_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
